// File: rtl/PKG_pwm.sv
// Shared PWM types used by the PWM carrier blocks.
package PKG_pwm;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

endpackage

// File: rtl/pwm_carrier_cmp.sv
// PWM carrier (sawtooth/triangle) generator with shadowed period/compare,
// duty comparator and complementary gate outputs with programmable dead-time.
module pwm_carrier_cmp
  import PKG_pwm::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int DT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 div_clk,
  input  _pwm_onoff            pwm_onoff,
  input  logic                 mode,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] compare,
  input  logic [DT_WIDTH-1:0]  deadtime,
  output logic [CNT_WIDTH-1:0] carrier,
  output logic                 pwm_h,
  output logic                 pwm_l,
  output logic                 period_end
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [DT_WIDTH-1:0]  DT_ONE  = 1;

  logic                 div_clk_q;
  logic                 tick;
  logic                 raw;
  logic                 raw_q;
  logic                 running;
  logic                 boundary;
  dir_t                 dir;
  dir_t                 dir_nxt;
  logic [CNT_WIDTH-1:0] period_sh;
  logic [CNT_WIDTH-1:0] compare_sh;
  logic [CNT_WIDTH-1:0] carrier_nxt;
  logic [DT_WIDTH-1:0]  dt_cnt;

  // div_clk is plain data; keep sampling it while idle so the first rise after
  // leaving PWM_OFF is seen as a genuine edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_clk_q <= 1'b0;
    end else begin
      div_clk_q <= div_clk;
    end
  end

  always_comb begin
    carrier_nxt = carrier;
    dir_nxt     = dir;
    boundary    = 1'b0;
    if (mode == 1'b0) begin
      dir_nxt = DIR_UP;
      if (carrier >= period_sh) begin
        carrier_nxt = '0;
        boundary    = 1'b1;
      end else begin
        carrier_nxt = carrier + CNT_ONE;
      end
    end else if (period_sh == '0) begin
      carrier_nxt = '0;
      dir_nxt     = DIR_UP;
      boundary    = 1'b1;
    end else if (dir == DIR_UP) begin
      // ">=" lets the carrier turn around even if a shadow load shrank the period
      if (carrier >= period_sh) begin
        dir_nxt     = DIR_DOWN;
        carrier_nxt = carrier - CNT_ONE;
      end else begin
        carrier_nxt = carrier + CNT_ONE;
      end
    end else begin
      if (carrier == '0) begin
        dir_nxt     = DIR_UP;
        carrier_nxt = carrier + CNT_ONE;
        boundary    = 1'b1;
      end else begin
        carrier_nxt = carrier - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || pwm_onoff == PWM_OFF) begin
      tick       <= 1'b0;
      carrier    <= '0;
      dir        <= DIR_UP;
      period_sh  <= period;
      compare_sh <= compare;
      period_end <= 1'b0;
      raw        <= 1'b0;
      raw_q      <= 1'b0;
      running    <= 1'b0;
      dt_cnt     <= '0;
      pwm_h      <= 1'b0;
      pwm_l      <= 1'b0;
    end else begin
      tick       <= div_clk & ~div_clk_q;
      raw        <= (carrier < compare_sh);
      raw_q      <= raw;
      period_end <= tick & boundary;
      if (tick) begin
        carrier <= carrier_nxt;
        dir     <= dir_nxt;
        if (boundary) begin
          period_sh  <= period;
          compare_sh <= compare;
        end
      end

      // dt_cnt holds the number of all-low cycles still owed, counting the current one
      if (!running) begin
        running <= 1'b1;
        dt_cnt  <= deadtime;
        pwm_h   <= 1'b0;
        pwm_l   <= 1'b0;
      end else if (raw != raw_q) begin
        dt_cnt <= deadtime;
        pwm_h  <= (deadtime == '0) && raw;
        pwm_l  <= (deadtime == '0) && !raw;
      end else if (dt_cnt > DT_ONE) begin
        dt_cnt <= dt_cnt - DT_ONE;
        pwm_h  <= 1'b0;
        pwm_l  <= 1'b0;
      end else begin
        dt_cnt <= '0;
        pwm_h  <= raw;
        pwm_l  <= ~raw;
      end
    end
  end

endmodule

// File: tb/tb_pwm_carrier_cmp.sv
// Scoreboard bench for pwm_carrier_cmp: carrier events and gate run lengths
// are queued as expectations and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_pwm_carrier_cmp;
  import PKG_pwm::*;

  localparam int CW = 16;
  localparam int DW = 8;

  typedef struct packed {
    logic [CW-1:0] car;
    logic          pend;
  } car_ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          div_clk = 1'b0;
  _pwm_onoff     pwm_onoff = PWM_ON;
  logic          mode = 1'b0;
  logic [CW-1:0] period = '0;
  logic [CW-1:0] compare = '0;
  logic [DW-1:0] deadtime = '0;
  logic [CW-1:0] carrier;
  logic          pwm_h;
  logic          pwm_l;
  logic          period_end;

  car_ev_t car_q[$];
  int      h_q[$];
  int      l_q[$];
  int      g_q[$];
  int      checks = 0;
  int      errors = 0;
  logic    mon_en = 1'b0;
  int      h_len = 0;
  int      l_len = 0;
  int      g_len = 0;
  logic [CW-1:0] prev_car = '0;

  int saw_seq[10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
  int tri_seq[13] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 1};
  int tri_end[13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};

  pwm_carrier_cmp #(.CNT_WIDTH(CW), .DT_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .div_clk    (div_clk),
    .pwm_onoff  (pwm_onoff),
    .mode       (mode),
    .period     (period),
    .compare    (compare),
    .deadtime   (deadtime),
    .carrier    (carrier),
    .pwm_h      (pwm_h),
    .pwm_l      (pwm_l),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  // Divided clock: toggles every 2 clk, so one rising edge every 4 clk
  initial begin
    forever begin
      repeat (2) @(posedge clk);
      #1 div_clk = ~div_clk;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic m, input int p, input int c, input int d);
    mode     = m;
    period   = CW'(p);
    compare  = CW'(c);
    deadtime = DW'(d);
  endtask

  task automatic pushCar(input int c, input int p);
    car_ev_t ev;
    ev.car  = CW'(c);
    ev.pend = (p != 0);
    car_q.push_back(ev);
  endtask

  task automatic doReset();
    @(negedge clk); #1;
    reset     = 1'b1;
    mon_en    = 1'b0;
    pwm_onoff = PWM_ON;
    @(negedge clk); #1;
    checkOutput("rst_carrier", 32'(carrier), 0);
    checkOutput("rst_pwm_h", 32'(pwm_h), 0);
    checkOutput("rst_pwm_l", 32'(pwm_l), 0);
    checkOutput("rst_period_end", 32'(period_end), 0);
    @(negedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic waitCarrier(input int v, input int budget, input string tag);
    int n = 0;
    while (carrier != CW'(v) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput(tag, 32'(carrier), 32'(v));
  endtask

  // sel 0 waits for pwm_h, sel 1 for period_end
  task automatic waitBit(input int sel, input int budget, input string tag);
    int   n = 0;
    logic b;
    b = (sel == 0) ? pwm_h : period_end;
    while (!b && n < budget) begin
      @(negedge clk); #1;
      n++;
      b = (sel == 0) ? pwm_h : period_end;
    end
    checkOutput(tag, 32'(b), 1);
  endtask

  task automatic drainCheck(input string tag);
    checkOutput({tag, "_car_left"}, 32'(car_q.size()), 0);
    checkOutput({tag, "_h_left"}, 32'(h_q.size()), 0);
    checkOutput({tag, "_l_left"}, 32'(l_q.size()), 0);
    checkOutput({tag, "_gap_left"}, 32'(g_q.size()), 0);
    car_q.delete();
    h_q.delete();
    l_q.delete();
    g_q.delete();
  endtask

  // Monitor: pops carrier events on every carrier change and run lengths on
  // every falling edge of pwm_h, pwm_l and the both-low gap. -1 means skip.
  initial begin
    car_ev_t ev;
    int      e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        h_len    = 0;
        l_len    = 0;
        g_len    = 0;
        prev_car = carrier;
      end else begin
        checkOutput("overlap", 32'(pwm_h & pwm_l), 0);
        if (carrier != prev_car) begin
          if (car_q.size() > 0) begin
            ev = car_q.pop_front();
            checkOutput("carrier", 32'(carrier), 32'(ev.car));
            checkOutput("period_end", 32'(period_end), 32'(ev.pend));
          end
          prev_car = carrier;
        end else begin
          checkOutput("pend_idle", 32'(period_end), 0);
        end
        if (pwm_h) h_len++;
        else if (h_len > 0) begin
          if (h_q.size() > 0) begin
            e = h_q.pop_front();
            if (e >= 0) checkOutput("h_run", 32'(h_len), 32'(e));
          end
          h_len = 0;
        end
        if (pwm_l) l_len++;
        else if (l_len > 0) begin
          if (l_q.size() > 0) begin
            e = l_q.pop_front();
            if (e >= 0) checkOutput("l_run", 32'(l_len), 32'(e));
          end
          l_len = 0;
        end
        if (!pwm_h && !pwm_l) g_len++;
        else if (g_len > 0) begin
          if (g_q.size() > 0) begin
            e = g_q.pop_front();
            if (e >= 0) checkOutput("gap_run", 32'(g_len), 32'(e));
          end
          g_len = 0;
        end
      end
    end
  end

  initial begin
    // Sawtooth P=4 C=2: 5 ticks per period, pwm_h for carrier 0..1
    applyStimulus(1'b0, 4, 2, 0);
    doReset();
    foreach (saw_seq[i]) pushCar(saw_seq[i], (saw_seq[i] == 0) ? 1 : 0);
    h_q = '{-1, 8, 8};
    l_q = '{12, 12};
    repeat (60) @(negedge clk);
    #1 drainCheck("saw");

    // Triangle P=3 C=2: boundary when the carrier turns up at 0
    applyStimulus(1'b1, 3, 2, 0);
    doReset();
    foreach (tri_seq[i]) pushCar(tri_seq[i], tri_end[i]);
    h_q = '{-1, 12, 12};
    l_q = '{12, 12};
    repeat (64) @(negedge clk);
    #1 drainCheck("tri");

    // Shadowed compare: new duty only from the next boundary
    applyStimulus(1'b0, 9, 5, 0);
    doReset();
    h_q = '{-1, 20, 32};
    l_q = '{20, 20, 8};
    waitBit(1, 60, "wait_boundary");
    waitCarrier(3, 20, "wait_car3");
    compare = CW'(8);
    repeat (80) @(negedge clk);
    #1 drainCheck("shadow");

    // Dead-time of 3 clk at every raw transition
    applyStimulus(1'b0, 4, 2, 3);
    doReset();
    g_q = '{-1, 3, 3, 3, 3};
    h_q = '{-1, 5, 5};
    l_q = '{9, 9};
    repeat (64) @(negedge clk);
    #1 drainCheck("dt");

    // Edge compares P=5: compare 0 then compare 6
    applyStimulus(1'b0, 5, 0, 2);
    doReset();
    g_q = '{-1, 2};
    repeat (20) @(negedge clk);
    repeat (5) begin
      repeat (4) @(negedge clk);
      #1;
      checkOutput("cmp0_l", 32'(pwm_l), 1);
      checkOutput("cmp0_h", 32'(pwm_h), 0);
    end
    compare = CW'(6);
    repeat (40) @(negedge clk);
    repeat (5) begin
      repeat (4) @(negedge clk);
      #1;
      checkOutput("cmp6_h", 32'(pwm_h), 1);
      checkOutput("cmp6_l", 32'(pwm_l), 0);
    end
    drainCheck("edge");

    // PWM_OFF at carrier 3, resume, then reset mid-period
    applyStimulus(1'b0, 9, 5, 0);
    doReset();
    waitCarrier(3, 40, "wait_off_car3");
    pushCar(0, 0);
    pwm_onoff = PWM_OFF;
    @(negedge clk); #1;
    checkOutput("off_carrier", 32'(carrier), 0);
    checkOutput("off_pwm_h", 32'(pwm_h), 0);
    checkOutput("off_pwm_l", 32'(pwm_l), 0);
    repeat (9) @(negedge clk);
    #1;
    checkOutput("off_hold_carrier", 32'(carrier), 0);
    checkOutput("off_hold_pwm_l", 32'(pwm_l), 0);
    pushCar(1, 0);
    pushCar(2, 0);
    pwm_onoff = PWM_ON;
    @(negedge clk); #1;
    checkOutput("exit_pwm_h", 32'(pwm_h), 0);
    checkOutput("exit_pwm_l", 32'(pwm_l), 0);
    checkOutput("exit_carrier", 32'(carrier), 0);
    waitBit(0, 20, "wait_exit_h");
    waitCarrier(2, 20, "wait_car2");
    @(negedge clk); #1;
    checkOutput("pre_rst_h", 32'(pwm_h), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_pwm_h", 32'(pwm_h), 0);
    checkOutput("midrst_pwm_l", 32'(pwm_l), 0);
    checkOutput("midrst_carrier", 32'(carrier), 0);
    @(negedge clk); #1;
    reset = 1'b0;
    drainCheck("off");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
